stdp_weight_update_engine: RTL and testbench
============================================

// Module: stdp_weight_update_engine
// PURPOSE
//  Parametrised STDP weight-update sweep for one post-synaptic neuron's weight RAM column.
//  On start, reads every synapse weight 0..N_SYN-1, computes a bounded delta, writes it back.
//  Successor of the fixed 784x24 updater: generic width/depth/fraction, correct-sign depression, optional clamp.
//  Sits in layer_block between the spike/STDP controller (start, dir, deltas) and a 1R1W sync weight RAM.
// PARAMETERS
//  W       24      weight/delta width, signed Q(W-FRAC-?).12 fixed point
//  N_SYN   784     synapses per sweep (>=1)
//  AW      10      RAM address width, 2**AW >= N_SYN
//  FRAC    8       arithmetic right shift applied to diff*delta product
//  WMAX    6144    upper weight bound (1.5*4096), signed W-bit
//  WMIN   -4915    lower weight bound (-1.2*4096), signed W-bit
// PORTS
//  clk          in   1    clock, all state on rising edge
//  rst          in   1    synchronous, active-high reset
//  start        in   1    1-cycle request; ignored while busy
//  dir          in   1    1 = potentiate (toward WMAX), 0 = depress (toward WMIN); sampled with start
//  del_w_plus   in   W    unsigned depression rate; sampled with start
//  del_w_minus  in   W    unsigned potentiation rate; sampled with start
//  rd_data      in   W    signed RAM read data, valid 1 cycle after rd_addr/rd_en
//  rd_addr      out  AW   RAM read address
//  rd_en        out  1    RAM read enable
//  wr_addr      out  AW   RAM write address
//  wr_data      out  W    signed RAM write data
//  wr_en        out  1    RAM write enable
//  busy         out  1    high from cycle after accepted start until done
//  done         out  1    1-cycle pulse, sweep complete
// BEHAVIOUR
//  Reset: all outputs 0, FSM IDLE, counters/pipeline cleared, latched dir/deltas 0.
//  FSM: IDLE -(start)-> READ -(rd_addr==N_SYN-1 issued)-> DRAIN -(last write)-> DONE -> IDLE.
//  READ: rd_en=1, rd_addr increments 0..N_SYN-1, one per cycle, no wrap, no gaps.
//  Pipeline per address k (rd_addr=k in cycle c):
//   c+1 rd_data valid; P1 latches w_old, diff = dir ? WMAX-w : w-WMIN (W+1 bits signed).
//   c+2 P2: prod = diff * delta (delta = dir ? del_w_minus : del_w_plus), 2W+1 bits signed.
//   c+3 P3: step = prod >>> FRAC; new = dir ? w_old+step : w_old-step (W+2 bits).
//   c+4 wr_en=1, wr_addr=k, wr_data=new reduced to W bits (see CONFIGURATION).
//  Timing: start in cycle 0 -> rd_addr=0 cycle 1 -> last write cycle N_SYN+4 -> done cycle N_SYN+5.
//  busy high cycles 1..N_SYN+5 inclusive of done cycle; deasserts with done's fall.
//  start while busy: dropped, no effect on latched dir/deltas. start in done cycle: dropped.
//  Back-to-back: start in cycle N_SYN+6 accepted normally.
//  Read/write same address never overlap in a cycle except via RAM read-first; engine never rereads k.
//  rst mid-sweep: next edge all outputs 0, FSM IDLE; partial writes remain in RAM, no done pulse.
//  N_SYN=1: READ lasts 1 cycle, one write in cycle 5, done in cycle 6.
//  delta=0: all writes return w_old unchanged (writes still issued).
// CONFIGURATION
//  `STDP_WCLAMP_EN defined: new saturated to [WMIN, WMAX] before wr_data.
//  Not defined: new truncated to low W bits (two's-complement wrap), no bound check.
// STRUCTURE
//  header.vh: `W default, WMAX/WMIN Q12 constants, shared FSM state encodings.
//  Sub-module stdp_delta_pipe: P1-P3 arithmetic with valid/addr sideband; engine owns FSM, counter, RAM ports.
// TESTING (W=24, FRAC=8, WMAX=6144, WMIN=-4915, N_SYN=4)
//  RAM all 0, dir=1, del_w_minus=32 -> wr_data=768 at addrs 0..3, wr_en cycles 5..8, done cycle 9.
//  RAM all 0, dir=0, del_w_plus=32 -> diff=4915, prod=157280, wr_data=-614 at all addrs.
//  RAM all 0, dir=1, del_w_minus=512 -> with STDP_WCLAMP_EN wr_data=6144; without 12288.
//  start re-pulsed in cycles 2 and 9 with different dir -> ignored, outputs match first sweep.
//  rst asserted cycle 4 -> wr_en/busy/rd_en 0 from cycle 5, no done; new start sweeps from addr 0.
//  RAM=[6144,-4915,100,-100], dir=1, del=256 -> wr_data=[6144,6144 clamped/6144,6144,6144] check bounds exact.

Source files
------------

// File: rtl/stdp_weight_update_engine_pkg.sv
// Shared constants and FSM state encoding for the STDP weight-update engine.
// Weight constants are Q12 fixed point (4096 = 1.0).
package stdp_weight_update_engine_pkg;

    localparam int W_DEF    = 24;
    localparam int WMAX_Q12 = 6144;
    localparam int WMIN_Q12 = -4915;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_READ,
        ST_DRAIN,
        ST_DONE
    } stdp_state_t;

endpackage

// File: rtl/stdp_weight_update_engine_delta_pipe.sv
// Three-stage STDP arithmetic: diff to bound, diff*delta, shifted step applied to w_old; addr/valid ride alongside.
// Latency 3 cycles from in_vld to out_vld, no backpressure; saturation to [WMIN,WMAX] when STDP_WCLAMP_EN is defined.
module stdp_weight_update_engine_delta_pipe #(
    parameter int W    = 24,
    parameter int AW   = 10,
    parameter int FRAC = 8,
    parameter int WMAX = 6144,
    parameter int WMIN = -4915
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_vld,
    input  logic [AW-1:0]        in_addr,
    input  logic signed [W-1:0]  in_w,
    input  logic                 dir,
    input  logic [W-1:0]         del_w_plus,
    input  logic [W-1:0]         del_w_minus,
    output logic                 out_vld,
    output logic [AW-1:0]        out_addr,
    output logic signed [W-1:0]  out_data
);

    localparam logic signed [W:0]   WMAX_X = (W+1)'(WMAX);
    localparam logic signed [W:0]   WMIN_X = (W+1)'(WMIN);
    localparam logic signed [W+1:0] WMAX_N = (W+2)'(WMAX);
    localparam logic signed [W+1:0] WMIN_N = (W+2)'(WMIN);

    logic signed [W:0]     w_ext;
    logic signed [W:0]     diff_c;
    logic signed [W:0]     delta_x;
    logic signed [2*W+1:0] prod_c;
    logic signed [2*W:0]   step_c;
    logic signed [W+1:0]   w2_ext;
    logic signed [W+1:0]   new_c;
    logic signed [W-1:0]   red_c;

    logic                v1, v2;
    logic [AW-1:0]       a1, a2;
    logic signed [W-1:0] w1, w2;
    logic signed [W:0]   diff1;
    logic signed [2*W:0] prod2;

    assign w_ext   = {in_w[W-1], in_w};
    assign diff_c  = dir ? (WMAX_X - w_ext) : (w_ext - WMIN_X);
    assign delta_x = {1'b0, (dir ? del_w_minus : del_w_plus)};
    assign prod_c  = $signed({{(W+1){diff1[W]}}, diff1}) * $signed({{(W+1){delta_x[W]}}, delta_x});
    assign step_c  = prod2 >>> FRAC;
    assign w2_ext  = {{2{w2[W-1]}}, w2};
    assign new_c   = dir ? (w2_ext + $signed(step_c[W+1:0])) : (w2_ext - $signed(step_c[W+1:0]));

    always_comb begin
        red_c = new_c[W-1:0];
`ifdef STDP_WCLAMP_EN
        if (new_c > WMAX_N) begin
            red_c = WMAX_N[W-1:0];
        end else if (new_c < WMIN_N) begin
            red_c = WMIN_N[W-1:0];
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            v1       <= 1'b0;
            v2       <= 1'b0;
            out_vld  <= 1'b0;
            a1       <= '0;
            a2       <= '0;
            out_addr <= '0;
            w1       <= '0;
            w2       <= '0;
            diff1    <= '0;
            prod2    <= '0;
            out_data <= '0;
        end else begin
            v1       <= in_vld;
            a1       <= in_addr;
            w1       <= in_w;
            diff1    <= diff_c;
            v2       <= v1;
            a2       <= a1;
            w2       <= w1;
            prod2    <= prod_c[2*W:0];
            out_vld  <= v2;
            out_addr <= a2;
            out_data <= red_c;
        end
    end

endmodule

// File: rtl/stdp_weight_update_engine.sv
// STDP sweep over one weight column: reads 0..N_SYN-1 one per cycle, writes updated weight 4 cycles later, done at N_SYN+5.
// No backpressure; start is dropped while busy. Define STDP_WCLAMP_EN to saturate written weights to [WMIN,WMAX].
module stdp_weight_update_engine
    import stdp_weight_update_engine_pkg::*;
#(
    parameter int W     = W_DEF,
    parameter int N_SYN = 784,
    parameter int AW    = 10,
    parameter int FRAC  = 8,
    parameter int WMAX  = WMAX_Q12,
    parameter int WMIN  = WMIN_Q12
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 dir,
    input  logic [W-1:0]         del_w_plus,
    input  logic [W-1:0]         del_w_minus,
    input  logic signed [W-1:0]  rd_data,
    output logic [AW-1:0]        rd_addr,
    output logic                 rd_en,
    output logic [AW-1:0]        wr_addr,
    output logic signed [W-1:0]  wr_data,
    output logic                 wr_en,
    output logic                 busy,
    output logic                 done
);

    localparam logic [AW-1:0] LAST = AW'(N_SYN - 1);

    stdp_state_t   state, state_nxt;
    logic [AW-1:0] cnt;
    logic          dir_q;
    logic [W-1:0]  dplus_q, dminus_q;
    logic          rd_vld_q;
    logic [AW-1:0] rd_addr_q;

    assign rd_en   = (state == ST_READ);
    assign rd_addr = cnt;
    assign busy    = (state != ST_IDLE);
    assign done    = (state == ST_DONE);

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (start) state_nxt = ST_READ;
            ST_READ:  if (cnt == LAST) state_nxt = ST_DRAIN;
            // The last write leaving the pipe ends the sweep.
            ST_DRAIN: if (wr_en && (wr_addr == LAST)) state_nxt = ST_DONE;
            ST_DONE:  state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            dir_q     <= 1'b0;
            dplus_q   <= '0;
            dminus_q  <= '0;
            rd_vld_q  <= 1'b0;
            rd_addr_q <= '0;
        end else begin
            state     <= state_nxt;
            rd_vld_q  <= rd_en;
            rd_addr_q <= rd_addr;
            if ((state == ST_IDLE) && start) begin
                dir_q    <= dir;
                dplus_q  <= del_w_plus;
                dminus_q <= del_w_minus;
            end
            if (state == ST_READ) begin
                cnt <= (cnt == LAST) ? '0 : cnt + AW'(1);
            end
        end
    end

    stdp_weight_update_engine_delta_pipe #(
        .W    (W),
        .AW   (AW),
        .FRAC (FRAC),
        .WMAX (WMAX),
        .WMIN (WMIN)
    ) u_pipe (
        .clk         (clk),
        .rst         (rst),
        .in_vld      (rd_vld_q),
        .in_addr     (rd_addr_q),
        .in_w        (rd_data),
        .dir         (dir_q),
        .del_w_plus  (dplus_q),
        .del_w_minus (dminus_q),
        .out_vld     (wr_en),
        .out_addr    (wr_addr),
        .out_data    (wr_data)
    );

endmodule

// File: tb/tb_stdp_weight_update_engine.sv
// Scoreboard bench for the STDP sweep engine with a behavioural RAM and an arithmetic reference model.
module tb_stdp_weight_update_engine;

    localparam int W    = 24;
    localparam int N    = 4;
    localparam int AW   = 3;
    localparam int FRAC = 8;
    localparam int WMAX = 6144;
    localparam int WMIN = -4915;

    logic                clk = 1'b0;
    logic                rst, start, dir;
    logic [W-1:0]        del_w_plus, del_w_minus;
    logic signed [W-1:0] rd_data;
    logic [AW-1:0]       rd_addr, wr_addr;
    logic                rd_en, wr_en, busy, done;
    logic signed [W-1:0] wr_data;

    stdp_weight_update_engine #(
        .W(W), .N_SYN(N), .AW(AW), .FRAC(FRAC), .WMAX(WMAX), .WMIN(WMIN)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .dir(dir),
        .del_w_plus(del_w_plus), .del_w_minus(del_w_minus),
        .rd_data(rd_data), .rd_addr(rd_addr), .rd_en(rd_en),
        .wr_addr(wr_addr), .wr_data(wr_data), .wr_en(wr_en),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // 1R1W synchronous RAM, read-first; ld_* lets the bench preload it while idle
    logic signed [W-1:0] ram [0:(1<<AW)-1];
    logic                ld_en = 1'b0;
    logic [AW-1:0]       ld_addr = '0;
    logic signed [W-1:0] ld_data = '0;
    always @(posedge clk) begin
        if (rd_en) rd_data <= ram[rd_addr];
        if (wr_en) ram[wr_addr] <= wr_data;
        else if (ld_en) ram[ld_addr] <= ld_data;
    end

    typedef struct {
        int     addr;
        longint data;
        int     cyc;
    } exp_t;

    exp_t rd_q[$];
    exp_t wr_q[$];
    int   done_q[$];

    int checks = 0;
    int failures = 0;
    int last_s = -1000;
    int next_free = 0;
    bit mon_en = 1'b0;
    bit zchk = 1'b0;
    bit flush = 1'b0;
    bit fin = 1'b0;

    function automatic longint ref_new(longint w, bit d, longint dp, longint dm);
        longint diff, del, step, nv;
        logic signed [W-1:0] tr;
        diff = d ? (WMAX - w) : (w - WMIN);
        del  = d ? dm : dp;
        step = (diff * del) >>> FRAC;
        nv   = d ? (w + step) : (w - step);
`ifdef STDP_WCLAMP_EN
        if (nv > WMAX) nv = WMAX;
        if (nv < WMIN) nv = WMIN;
        tr = nv[W-1:0];
`else
        tr = nv[W-1:0];
`endif
        return longint'(tr);
    endfunction

    task automatic chk(input string nm, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Monitor: pops expectations whenever the DUT presents a read, write or done
    always @(negedge clk) begin
        exp_t e;
        if (flush) begin
            rd_q.delete();
            wr_q.delete();
            done_q.delete();
        end
        if (mon_en) begin
            chk("busy", longint'(busy), longint'((cyc >= last_s + 1) && (cyc <= last_s + N + 5)));
            if (zchk) begin
                chk("zero_rd_en", longint'(rd_en), 0);
                chk("zero_rd_addr", longint'(rd_addr), 0);
                chk("zero_wr_en", longint'(wr_en), 0);
                chk("zero_wr_addr", longint'(wr_addr), 0);
                chk("zero_wr_data", longint'(wr_data), 0);
                chk("zero_busy", longint'(busy), 0);
                chk("zero_done", longint'(done), 0);
            end
            if (rd_en) begin
                if (rd_q.size() == 0) begin
                    chk("unexpected_read_addr", longint'(rd_addr), -1);
                end else begin
                    e = rd_q.pop_front();
                    chk("rd_addr", longint'(rd_addr), e.addr);
                    chk("rd_cycle", cyc, e.cyc);
                end
            end
            if (wr_en) begin
                if (wr_q.size() == 0) begin
                    chk("unexpected_write_addr", longint'(wr_addr), -1);
                end else begin
                    e = wr_q.pop_front();
                    chk("wr_addr", longint'(wr_addr), e.addr);
                    chk("wr_data", longint'(wr_data), e.data);
                    chk("wr_cycle", cyc, e.cyc);
                end
            end
            if (done) begin
                if (done_q.size() == 0) chk("unexpected_done_cycle", cyc, -1);
                else chk("done_cycle", cyc, done_q.pop_front());
            end
            if (fin) begin
                chk("rd_q_left", rd_q.size(), 0);
                chk("wr_q_left", wr_q.size(), 0);
                chk("done_q_left", done_q.size(), 0);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_cyc(input int t);
        while (cyc < t) tick();
    endtask

    task automatic wait_idle();
        wait_cyc(next_free + 1);
    endtask

    task automatic load_ram(input int v[N]);
        wait_idle();
        for (int k = 0; k < N; k++) begin
            ld_en   = 1'b1;
            ld_addr = AW'(k);
            ld_data = W'(v[k]);
            tick();
        end
        ld_en = 1'b0;
        tick();
    endtask

    task automatic start_sweep(input bit d, input int dp, input int dm, output int s);
        exp_t e;
        start       = 1'b1;
        dir         = d;
        del_w_plus  = W'(dp);
        del_w_minus = W'(dm);
        s = cyc;
        if (s >= next_free) begin
            for (int k = 0; k < N; k++) begin
                e.addr = k; e.data = 0; e.cyc = s + 1 + k;
                rd_q.push_back(e);
                e.data = ref_new(longint'(ram[k]), d, dp, dm);
                e.cyc  = s + 5 + k;
                wr_q.push_back(e);
            end
            done_q.push_back(s + N + 5);
            last_s    = s;
            next_free = s + N + 6;
        end
        tick();
        start = 1'b0;
    endtask

    task automatic sweep(input int v[N], input bit d, input int dp, input int dm);
        int s;
        load_ram(v);
        start_sweep(d, dp, dm, s);
    endtask

    initial begin
        int s, t;
        int zeros[N];
        int bounds[N];
        int wrapv[N];
        int rv[N];
        zeros  = '{0, 0, 0, 0};
        bounds = '{WMAX, WMIN, 100, -100};
        wrapv  = '{WMIN, 0, 6000, -100};
        rst = 1'b1; start = 1'b0; dir = 1'b0;
        del_w_plus = '0; del_w_minus = '0;
        for (int k = 0; k < (1 << AW); k++) ram[k] = '0;

        repeat (2) @(posedge clk);
        #1;
        mon_en = 1'b1;
        zchk   = 1'b1;
        tick();
        zchk = 1'b0;
        rst  = 1'b0;
        next_free = cyc;

        sweep(zeros, 1'b1, 7, 32);
        sweep(zeros, 1'b0, 32, 5);
        sweep(zeros, 1'b1, 0, 512);
        sweep(bounds, 1'b1, 0, 256);
        sweep(wrapv, 1'b1, 0, 200000);
        sweep(bounds, 1'b0, 0, 0);

        // Re-pulses while busy and in the done cycle are dropped; next cycle is accepted
        rv = '{1000, -2000, 3000, -4000};
        load_ram(rv);
        start_sweep(1'b0, 40, 90, s);
        wait_cyc(s + 2);
        start_sweep(1'b1, 300, 300, t);
        wait_cyc(s + 9);
        start_sweep(1'b1, 200, 200, t);
        start_sweep(1'b1, 11, 77, t);

        // Reset mid-sweep: no writes, no done, then a fresh sweep from address 0
        load_ram(zeros);
        start_sweep(1'b1, 0, 32, s);
        wait_cyc(s + 4);
        rst = 1'b1;
        tick();
        rst       = 1'b0;
        flush     = 1'b1;
        zchk      = 1'b1;
        last_s    = -1000;
        next_free = cyc;
        tick();
        flush = 1'b0;
        zchk  = 1'b0;
        repeat (3) tick();
        start_sweep(1'b0, 64, 0, s);

        for (int i = 0; i < 10; i++) begin
            for (int k = 0; k < N; k++) rv[k] = int'($urandom_range(0, WMAX - WMIN + 600)) + WMIN - 300;
            sweep(rv, 1'($urandom_range(0, 1)), int'($urandom_range(0, 1023)), int'($urandom_range(0, 1023)));
        end

        wait_idle();
        fin = 1'b1;
        tick();
        fin = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
